control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 219 +++++++++++++++++++++
 tb/tb_control_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle control FSM: sequences FETCH/EXEC/LDWB and decodes the RV32 subset
// (OP, OP-IMM, LOAD, STORE, LUI, JAL) into datapath and memory controls.
module control_unit #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] instr,
  output logic        reg_WE,
  output logic        rs1_SEL,
  output logic        rs2_SEL,
  output logic        addrs_SEL,
  output logic        pc_EN,
  output logic        instr_EN,
  output logic        ALU_mem_EN,
  output logic        mem_in_EN,
  output logic        mem_WE,
  output logic [1:0]  reg_SEL,
  output logic [1:0]  pc_SEL,
  output logic [2:0]  imm_SEL,
  output logic [2:0]  mem_MODE,
  output logic [3:0]  ALU_MODE,
  output logic        halted,
  output logic        illegal
);

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned MODE_W  = 3;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_I = 3'b011;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b000;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RSEL_MEM = 2'b00;
  localparam logic [1:0] RSEL_ALU = 2'b01;
  localparam logic [1:0] RSEL_PC4 = 2'b10;
  localparam logic [1:0] RSEL_IMM = 2'b11;

  localparam logic [1:0] PSEL_PC4 = 2'b00;
  localparam logic [1:0] PSEL_IMM = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_LDWB  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [OPC_W-1:0]    opcode;
  logic [F3_W-1:0]     funct3;
  logic [MODE_W-1:0]   mem_mode_dec;
  logic [MODE_W-1:0]   mem_mode_q;
  logic                ls_f3_ok;
  logic                is_ls;
  logic                opc_known;
  logic                illegal_op;
  logic                unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Load/store width decode; unmapped funct3 values make the instruction illegal
  always_comb begin
    mem_mode_dec = '0;
    ls_f3_ok     = 1'b1;
    unique case (funct3)
      3'b010:  mem_mode_dec = 3'b000;
      3'b001:  mem_mode_dec = 3'b001;
      3'b000:  mem_mode_dec = 3'b010;
      3'b101:  mem_mode_dec = 3'b101;
      3'b100:  mem_mode_dec = 3'b110;
      default: ls_f3_ok     = 1'b0;
    endcase
  end

  // Legality of the instruction currently in the instruction register
  always_comb begin
    is_ls     = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    opc_known = (opcode == OPC_OP)   || (opcode == OPC_OP_IMM) || is_ls ||
                (opcode == OPC_LUI)  || (opcode == OPC_JAL);
    illegal_op = !opc_known || (is_ls && !ls_f3_ok);
  end

  // State register plus load width captured in EXEC for the writeback cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      mem_mode_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_EXEC) begin
        mem_mode_q <= mem_mode_dec;
      end
    end
  end

  // Next-state sequencing
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  state_nxt = run ? ST_FETCH : ST_IDLE;
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (illegal_op && HALT_ON_ILLEGAL) begin
          state_nxt = ST_HALT;
        end else if (!illegal_op && (opcode == OPC_LOAD)) begin
          state_nxt = ST_LDWB;
        end else begin
          state_nxt = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_LDWB:  state_nxt = run ? ST_FETCH : ST_IDLE;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Control decode from state and instruction; IDLE (and thus reset) drives all zero
  always_comb begin
    reg_WE     = 1'b0;
    rs1_SEL    = 1'b0;
    rs2_SEL    = 1'b0;
    addrs_SEL  = 1'b0;
    pc_EN      = 1'b0;
    instr_EN   = 1'b0;
    ALU_mem_EN = 1'b0;
    mem_in_EN  = 1'b0;
    mem_WE     = 1'b0;
    reg_SEL    = RSEL_MEM;
    pc_SEL     = PSEL_PC4;
    imm_SEL    = IMM_U;
    mem_MODE   = '0;
    ALU_MODE   = '0;
    halted     = 1'b0;
    illegal    = 1'b0;
    unique case (state)
      ST_FETCH: begin
        addrs_SEL = 1'b1;
        instr_EN  = 1'b1;
        mem_in_EN = 1'b1;
      end
      ST_EXEC: begin
        if (illegal_op) begin
          illegal = 1'b1;
          if (!HALT_ON_ILLEGAL) begin
            pc_EN = 1'b1;
          end
        end else begin
          pc_EN = 1'b1;
          unique case (opcode)
            OPC_OP: begin
              reg_SEL  = RSEL_ALU;
              reg_WE   = 1'b1;
              ALU_MODE = {instr[30], funct3};
            end
            OPC_OP_IMM: begin
              rs2_SEL  = 1'b1;
              imm_SEL  = IMM_I;
              reg_SEL  = RSEL_ALU;
              reg_WE   = 1'b1;
              ALU_MODE = {(funct3 == 3'b101) & instr[30], funct3};
            end
            OPC_STORE: begin
              rs2_SEL    = 1'b1;
              imm_SEL    = IMM_S;
              ALU_mem_EN = 1'b1;
              mem_WE     = 1'b1;
              mem_MODE   = mem_mode_dec;
            end
            OPC_LOAD: begin
              pc_EN      = 1'b0;
              rs2_SEL    = 1'b1;
              imm_SEL    = IMM_I;
              ALU_mem_EN = 1'b1;
              mem_in_EN  = 1'b1;
              mem_MODE   = mem_mode_dec;
            end
            OPC_LUI: begin
              imm_SEL = IMM_U;
              reg_SEL = RSEL_IMM;
              reg_WE  = 1'b1;
            end
            OPC_JAL: begin
              imm_SEL = IMM_J;
              reg_SEL = RSEL_PC4;
              reg_WE  = 1'b1;
              pc_SEL  = PSEL_IMM;
            end
            default: ;
          endcase
        end
      end
      ST_LDWB: begin
        reg_SEL  = RSEL_MEM;
        reg_WE   = 1'b1;
        pc_EN    = 1'b1;
        pc_SEL   = PSEL_PC4;
        mem_MODE = mem_mode_q;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a per-instruction sequence model pushes the
// expected control word for every cycle; a negedge monitor pops and compares.
module tb_control_unit;

  typedef struct packed {
    logic       reg_we;
    logic       rs1_sel;
    logic       rs2_sel;
    logic       addrs_sel;
    logic       pc_en;
    logic       instr_en;
    logic       alu_mem_en;
    logic       mem_in_en;
    logic       mem_we;
    logic [1:0] reg_sel;
    logic [1:0] pc_sel;
    logic [2:0] imm_sel;
    logic [2:0] mem_mode;
    logic [3:0] alu_mode;
    logic       halted;
    logic       illegal;
  } out_t;

  typedef struct {
    out_t        val;
    out_t        msk;
    logic [31:0] ins;
    int          ph;
  } sb_t;

  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_EXEC = 2, PH_LDWB = 3, PH_HALT = 4;

  // {legal, mem_mode} indexed by funct3
  localparam logic [3:0] MM_TAB [8] = '{4'b1010, 4'b1001, 4'b1000, 4'b0000,
                                        4'b1110, 4'b1101, 4'b0000, 4'b0000};
  localparam logic [2:0] LS_F3 [5] = '{3'b010, 3'b001, 3'b000, 3'b101, 3'b100};

  logic        clk = 1'b0;
  logic        reset, run;
  logic [31:0] instr;
  logic        reset2, run2;
  logic [31:0] instr2;

  logic reg_WE, rs1_SEL, rs2_SEL, addrs_SEL, pc_EN, instr_EN, ALU_mem_EN, mem_in_EN, mem_WE;
  logic [1:0] reg_SEL, pc_SEL;
  logic [2:0] imm_SEL, mem_MODE;
  logic [3:0] ALU_MODE;
  logic halted, illegal;

  logic reg_WE2, rs1_SEL2, rs2_SEL2, addrs_SEL2, pc_EN2, instr_EN2, ALU_mem_EN2, mem_in_EN2, mem_WE2;
  logic [1:0] reg_SEL2, pc_SEL2;
  logic [2:0] imm_SEL2, mem_MODE2;
  logic [3:0] ALU_MODE2;
  logic halted2, illegal2;

  out_t act, act2;
  assign act  = {reg_WE, rs1_SEL, rs2_SEL, addrs_SEL, pc_EN, instr_EN, ALU_mem_EN, mem_in_EN,
                 mem_WE, reg_SEL, pc_SEL, imm_SEL, mem_MODE, ALU_MODE, halted, illegal};
  assign act2 = {reg_WE2, rs1_SEL2, rs2_SEL2, addrs_SEL2, pc_EN2, instr_EN2, ALU_mem_EN2, mem_in_EN2,
                 mem_WE2, reg_SEL2, pc_SEL2, imm_SEL2, mem_MODE2, ALU_MODE2, halted2, illegal2};

  int   errors = 0;
  int   checks = 0;
  sb_t  sb_q[$];
  logic in_idle = 1'b1;

  always #5 clk = ~clk;

  control_unit #(.HALT_ON_ILLEGAL(1'b1)) u_dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr),
    .reg_WE(reg_WE), .rs1_SEL(rs1_SEL), .rs2_SEL(rs2_SEL), .addrs_SEL(addrs_SEL),
    .pc_EN(pc_EN), .instr_EN(instr_EN), .ALU_mem_EN(ALU_mem_EN), .mem_in_EN(mem_in_EN),
    .mem_WE(mem_WE), .reg_SEL(reg_SEL), .pc_SEL(pc_SEL), .imm_SEL(imm_SEL),
    .mem_MODE(mem_MODE), .ALU_MODE(ALU_MODE), .halted(halted), .illegal(illegal)
  );

  control_unit #(.HALT_ON_ILLEGAL(1'b0)) u_dut_nop (
    .clk(clk), .reset(reset2), .run(run2), .instr(instr2),
    .reg_WE(reg_WE2), .rs1_SEL(rs1_SEL2), .rs2_SEL(rs2_SEL2), .addrs_SEL(addrs_SEL2),
    .pc_EN(pc_EN2), .instr_EN(instr_EN2), .ALU_mem_EN(ALU_mem_EN2), .mem_in_EN(mem_in_EN2),
    .mem_WE(mem_WE2), .reg_SEL(reg_SEL2), .pc_SEL(pc_SEL2), .imm_SEL(imm_SEL2),
    .mem_MODE(mem_MODE2), .ALU_MODE(ALU_MODE2), .halted(halted2), .illegal(illegal2)
  );

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // ---------------- reference model: expected control word per cycle ----------------
  function automatic void exp_idle(output out_t v, output out_t m);
    v = '0; m = '0;
    m.halted = 1'b1; m.illegal = 1'b1;
    m.reg_we = 1'b1; m.pc_en = 1'b1; m.instr_en = 1'b1;
    m.alu_mem_en = 1'b1; m.mem_in_en = 1'b1; m.mem_we = 1'b1;
  endfunction

  function automatic void exp_fetch(output out_t v, output out_t m);
    exp_idle(v, m);
    v.addrs_sel = 1'b1; m.addrs_sel = 1'b1;
    v.instr_en  = 1'b1; v.mem_in_en = 1'b1;
    m.mem_mode  = 3'b111;
  endfunction

  function automatic void exp_halt(output out_t v, output out_t m);
    exp_idle(v, m);
    v.halted = 1'b1;
  endfunction

  // kind: 0 = two-cycle instruction, 1 = load, 2 = illegal
  function automatic void exp_exec(input logic [31:0] ins, output out_t v, output out_t m,
                                   output int kind);
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [3:0] mm  = MM_TAB[f3];
    v = '0; m = '0; kind = 0;
    m.halted = 1'b1; m.illegal = 1'b1;
    m.reg_we = 1'b1; m.mem_we = 1'b1; m.pc_en = 1'b1; m.instr_en = 1'b1; m.addrs_sel = 1'b1;
    v.pc_en = 1'b1; m.pc_sel = 2'b11;
    case (opc)
      7'b0110011: begin
        v.reg_we = 1'b1; m.rs1_sel = 1'b1; m.rs2_sel = 1'b1;
        v.reg_sel = 2'b01; m.reg_sel = 2'b11;
        v.alu_mode = {ins[30], f3}; m.alu_mode = 4'hF;
      end
      7'b0010011: begin
        v.reg_we = 1'b1; v.rs2_sel = 1'b1; m.rs2_sel = 1'b1;
        v.imm_sel = 3'b011; m.imm_sel = 3'b111;
        v.reg_sel = 2'b01; m.reg_sel = 2'b11;
        v.alu_mode = {(f3 == 3'b101) ? ins[30] : 1'b0, f3}; m.alu_mode = 4'hF;
      end
      7'b0100011: begin
        if (mm[3]) begin
          v.rs2_sel = 1'b1; m.rs2_sel = 1'b1;
          v.imm_sel = 3'b001; m.imm_sel = 3'b111;
          m.alu_mode = 4'hF;
          v.alu_mem_en = 1'b1; m.alu_mem_en = 1'b1;
          v.mem_we = 1'b1;
          v.mem_mode = mm[2:0]; m.mem_mode = 3'b111;
        end else kind = 2;
      end
      7'b0000011: begin
        if (mm[3]) begin
          kind = 1;
          v.pc_en = 1'b0; m.pc_sel = 2'b00;
          v.imm_sel = 3'b011; m.imm_sel = 3'b111;
          m.alu_mode = 4'hF;
          v.alu_mem_en = 1'b1; m.alu_mem_en = 1'b1;
          v.mem_in_en = 1'b1; m.mem_in_en = 1'b1;
          v.mem_mode = mm[2:0]; m.mem_mode = 3'b111;
        end else kind = 2;
      end
      7'b0110111: begin
        v.reg_we = 1'b1;
        v.imm_sel = 3'b000; m.imm_sel = 3'b111;
        v.reg_sel = 2'b11; m.reg_sel = 2'b11;
      end
      7'b1101111: begin
        v.reg_we = 1'b1;
        v.imm_sel = 3'b100; m.imm_sel = 3'b111;
        v.reg_sel = 2'b10; m.reg_sel = 2'b11;
        v.pc_sel = 2'b01;
      end
      default: kind = 2;
    endcase
    if (kind == 2) begin
      v = '0; m = '0;
      m.halted = 1'b1; m.illegal = 1'b1; v.illegal = 1'b1;
      m.reg_we = 1'b1; m.mem_we = 1'b1; m.pc_en = 1'b1;
    end
  endfunction

  function automatic void exp_ldwb(input logic [31:0] ins, output out_t v, output out_t m);
    logic [3:0] mm = MM_TAB[ins[14:12]];
    exp_idle(v, m);
    v.reg_we = 1'b1; v.pc_en = 1'b1;
    m.pc_sel = 2'b11; m.reg_sel = 2'b11;
    v.mem_mode = mm[2:0]; m.mem_mode = 3'b111;
  endfunction

  // ---------------- stimulus ----------------
  task automatic cyc(input out_t v, input out_t m, input logic r, input logic [31:0] ins,
                     input int ph);
    sb_t s;
    run = r; instr = ins;
    s.val = v; s.msk = m; s.ins = ins; s.ph = ph;
    sb_q.push_back(s);
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic r, output logic went_halt);
    out_t v, m;
    int   kind;
    went_halt = 1'b0;
    if (in_idle) begin
      exp_idle(v, m);
      repeat ($urandom_range(0, 2)) cyc(v, m, 1'b0, $urandom, PH_IDLE);
      cyc(v, m, 1'b1, $urandom, PH_IDLE);
    end
    exp_fetch(v, m);
    cyc(v, m, 1'($urandom_range(0, 1)), $urandom, PH_FETCH);
    exp_exec(ins, v, m, kind);
    if (kind == 2) begin
      cyc(v, m, 1'($urandom_range(0, 1)), ins, PH_EXEC);
      went_halt = 1'b1;
      return;
    end
    if (kind == 1) begin
      cyc(v, m, 1'($urandom_range(0, 1)), ins, PH_EXEC);
      exp_ldwb(ins, v, m);
      cyc(v, m, r, ins, PH_LDWB);
    end else begin
      cyc(v, m, r, ins, PH_EXEC);
    end
    in_idle = !r;
  endtask

  // Sits in HALT a few cycles, then clears it with an asynchronous reset pulse
  task automatic halt_and_reset();
    out_t v, m;
    exp_halt(v, m);
    repeat (3) cyc(v, m, 1'($urandom_range(0, 1)), $urandom, PH_HALT);
    #2 reset = 1'b0; run = 1'b0;
    #1 chk("halt_async_clear", 32'(act), 32'd0);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    in_idle = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int          k = $urandom_range(0, 99);
    logic [2:0]  lf = LS_F3[$urandom_range(0, 4)];
    if      (k < 15) w[6:0] = 7'b0110011;
    else if (k < 30) w[6:0] = 7'b0010011;
    else if (k < 45) begin w[6:0] = 7'b0100011; w[14:12] = lf; end
    else if (k < 62) begin w[6:0] = 7'b0000011; w[14:12] = lf; end
    else if (k < 72) w[6:0] = 7'b0110111;
    else if (k < 82) w[6:0] = 7'b1101111;
    else if (k < 90) w[6:0] = ($urandom_range(0, 1) != 0) ? 7'b0000011 : 7'b0100011;
    return w;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    sb_t s;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        s = sb_q.pop_front();
        checks++;
        if (((act ^ s.val) & s.msk) != '0) begin
          errors++;
          $display("FAIL cycle ph=%0d instr=%h: got %h expected %h (mask %h)",
                   s.ph, s.ins, act, s.val, s.msk);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic        hf;
    logic [31:0] ins;
    reset = 1'b0; run = 1'b0; instr = '0;
    reset2 = 1'b0; run2 = 1'b0; instr2 = '0;
    #12;
    chk("reset_outputs_zero", 32'(act), 32'd0);
    chk("reset_outputs_zero_nop", 32'(act2), 32'd0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    issue(32'h00800513, 1'b1, hf);
    issue(32'h00b505b3, 1'b1, hf);
    issue(32'h40b505b3, 1'b1, hf);
    issue(32'h00b52023, 1'b1, hf);
    issue(32'h00052603, 1'b0, hf);
    issue(32'h00052603, 1'b1, hf);
    issue(32'hFFFFFFFF, 1'b1, hf);
    if (hf) halt_and_reset();

    for (int i = 0; i < 250; i++) begin
      ins = rand_instr();
      issue(ins, 1'($urandom_range(0, 3) != 0), hf);
      if (hf) halt_and_reset();
    end
    issue(32'h00000013, 1'b0, hf);

    begin
      int n = 0;
      while (sb_q.size() != 0 && n < 50) begin
        @(posedge clk); #1; n++;
      end
      if (sb_q.size() != 0) begin
        chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
      end
    end

    // Reset during load writeback aborts the register write without a clock edge
    run = 1'b1; instr = $urandom;
    @(posedge clk); #1;
    chk("first_fetch_instr_en", 32'(instr_EN), 32'd1);
    instr = 32'h00052603;
    @(posedge clk); #1;
    chk("lw_exec_pc_en", 32'(pc_EN), 32'd0);
    @(posedge clk); #1;
    chk("ldwb_reg_we", 32'(reg_WE), 32'd1);
    #2 reset = 1'b0; run = 1'b0;
    #1 chk("reset_abort_reg_we", 32'(reg_WE), 32'd0);
    chk("reset_abort_all_zero", 32'(act), 32'd0);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("idle_enables_zero",
        32'({reg_WE, pc_EN, instr_EN, ALU_mem_EN, mem_in_EN, mem_WE, mem_WE}), 32'd0);
    run = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_fetch", 32'(instr_EN), 32'd1);

    // Illegal opcode retired as a NOP when halting is disabled
    #2 reset2 = 1'b1;
    @(posedge clk); #1;
    run2 = 1'b1; instr2 = 32'h0;
    @(posedge clk); #1;
    chk("nop_fetch", 32'(instr_EN2), 32'd1);
    instr2 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    chk("nop_illegal_pulse", 32'(illegal2), 32'd1);
    chk("nop_pc_en", 32'({pc_EN2, pc_SEL2}), 32'b100);
    chk("nop_no_writes", 32'({reg_WE2, mem_WE2, halted2}), 32'd0);
    @(posedge clk); #1;
    chk("nop_next_fetch", 32'({instr_EN2, illegal2, halted2}), 32'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
